mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter between the instruction/data cache and the single memory bus. Each cache side presents the same request/response handshake the memory bus uses. The arbiter grants one side at a time, holds that grant for a whole line transaction, and routes response beats back to the owner. It sits directly downstream of the cache and directly upstream of the memory model.

## Interface
- DATA_W, 64, bus data width (BUS_DATA_WIDTH)
- TAG_W, 13, bus tag width (BUS_TAG_WIDTH)
- BEATS, 8, data beats per line (64-byte line / 8-byte beat)
- READ_TAG, MEM_READ, reqtag value opening a read
- WRITE_TAG, MEM_WRITE, reqtag value opening a write
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- i_reqcyc / d_reqcyc  in  1  instruction / data side request valid
- i_req / d_req  in  DATA_W  request beat (address, then write data)
- i_reqtag / d_reqtag  in  TAG_W  request tag
- i_reqack / d_reqack  out  1  request beat accepted
- i_respcyc / d_respcyc  out  1  response beat valid
- i_resp / d_resp  out  DATA_W  response data
- i_resptag / d_resptag  out  TAG_W  response tag
- i_respack / d_respack  in  1  response beat consumed
- bus_reqcyc, bus_req, bus_reqtag  out  1/DATA_W/TAG_W  request to memory
- bus_reqack  in  1  memory accepted beat
- bus_respcyc, bus_resp, bus_resptag  in  1/DATA_W/TAG_W  memory response
- bus_respack  out  1  response consumed
- stray_resp  out  1  sticky: bus_respcyc seen while no read outstanding

## Operation
- A beat transfers on a rising edge where the cyc signal and its ack are both high. The sender holds cyc, data and tag stable until that edge.
- The FSM has five states: IDLE, I_REQ, D_REQ, I_RESP, D_RESP. A register `last` holds the side granted most recently.
- In IDLE, no bus outputs are driven. Next state is decided from the inputs sampled at the edge:
  - only d_reqcyc → D_REQ; only i_reqcyc → I_REQ;
  - both → the side that is not `last` wins (round-robin); `last` resets to instruction, so data wins the first tie;
  - entering X_REQ sets `last` = X.
- In X_REQ, bus_req* = X_req* and X_reqack = bus_reqack, both combinational. The other side's reqack is 0.
- The first accepted beat in X_REQ is the opening beat; its tag is latched as `is_write` = (tag == WRITE_TAG). Any tag other than WRITE_TAG is handled as a read.
- Read: after the opening beat is accepted, go to X_RESP.
- Write: stay in X_REQ until 1+BEATS beats are accepted, then go to IDLE. No response is expected.
- In X_RESP, X_respcyc/X_resp/X_resptag = bus_* and bus_respack = X_respack. The other side's respcyc is 0.
  - Count accepted beats; on the BEATS-th accepted beat go to IDLE.
- Beat counter width is $clog2(BEATS+2). It clears on entry to every X_REQ state.
- If bus_respcyc is high in IDLE, X_REQ or a write, then:
  - bus_respack stays 0;
  - the beat is never routed to either side;
  - stray_resp is set to 1 and stays set until reset.
- A non-granted side's reqcyc is ignored; it simply waits.

## Timing
- Reset values: state IDLE, `last` = instruction, counter 0, stray_resp 0.
  - All cyc/ack outputs are 0. Data and tag outputs are 0 whenever their cyc is 0.
- Reset asserted mid-transaction aborts immediately to IDLE with no beat completion. After deassertion, the first grant is decided at the first edge.
- Grant latency: request raised before edge N → granted state from edge N. bus_reqcyc is visible in cycle N, so there is one idle cycle of arbitration.
- Request path and response path are combinational pass-throughs: no added per-beat latency.
- After the final beat, the FSM spends at least one cycle in IDLE before the next grant.
- Maximum throughput is one beat per cycle when memory acks continuously.
- Read responses arriving in the same cycle as the opening-beat ack are stray; memory must respond at least one cycle later.

## Test plan
- Single I read: i_reqcyc, address 0x1000, tag READ; memory acks next cycle and returns 8 beats 0..7 → i_reqack pulses once; i_respcyc delivers 0..7 in order; d_* stays 0; FSM ends in IDLE.
- Simultaneous requests from reset: both raise reqcyc together → D is served first (read, 8 beats), then I. On the next tie with `last` = I, D wins again.
- D write: tag WRITE, address 0x2040 plus 8 data beats, bus_reqack held high → 9 beats appear on bus_req in order; no RESP state is entered; the arbiter is back in IDLE 9 cycles after the grant.
- Back-pressure: respcyc held high, X_respack toggled 1,0,1,... → exactly 8 beats are counted, bus_respack mirrors X_respack, and no beat is duplicated or lost.
- Stray response: bus_respcyc pulsed in IDLE → bus_respack stays 0 and stray_resp goes 1 and stays 1. Reset clears it to 0.
- Reset at the 4th response beat → all outputs are 0 at once; after release, a new I read completes normally with the counter restarting at 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master line-transaction arbiter in front of the memory bus
//
// Grants the instruction (i_*) or data (d_*) cache side one whole line
// transaction at a time and passes request beats out and response beats back
// combinationally. Ties are broken round-robin against the last grant.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   i_req*/d_req*         request beats from each cache side (cyc/data/tag, ack back)
//   i_resp*/d_resp*       response beats to each cache side (cyc/data/tag, ack in)
//   bus_req*              request beats to memory (cyc/data/tag, ack in)
//   bus_resp*             response beats from memory (cyc/data/tag, ack back)
//   stray_resp            sticky flag: memory responded while no read was outstanding
module mem_bus_arbiter #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13,
  parameter int BEATS  = 8,
  parameter logic [TAG_W-1:0] READ_TAG  = TAG_W'(1),
  parameter logic [TAG_W-1:0] WRITE_TAG = TAG_W'(2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_reqcyc,
  input  logic [DATA_W-1:0] i_req,
  input  logic [TAG_W-1:0]  i_reqtag,
  output logic              i_reqack,
  output logic              i_respcyc,
  output logic [DATA_W-1:0] i_resp,
  output logic [TAG_W-1:0]  i_resptag,
  input  logic              i_respack,
  input  logic              d_reqcyc,
  input  logic [DATA_W-1:0] d_req,
  input  logic [TAG_W-1:0]  d_reqtag,
  output logic              d_reqack,
  output logic              d_respcyc,
  output logic [DATA_W-1:0] d_resp,
  output logic [TAG_W-1:0]  d_resptag,
  input  logic              d_respack,
  output logic              bus_reqcyc,
  output logic [DATA_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [DATA_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack,
  output logic              stray_resp
);

  localparam int CW = $clog2(BEATS + 2);

  typedef enum logic [2:0] {S_IDLE, S_I_REQ, S_D_REQ, S_I_RESP, S_D_RESP} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;          // 1 = data side granted most recently
  logic [CW-1:0]   cnt_q, cnt_d;            // beats accepted in this transaction
  logic            is_write_q, is_write_d;
  logic            stray_q, stray_d;

  logic              own_d, in_req, in_resp;
  logic              x_reqcyc, x_respack;
  logic [DATA_W-1:0] x_req;
  logic [TAG_W-1:0]  x_reqtag;
  logic              req_fire, resp_fire, open_beat, beat_is_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      stray_q    <= stray_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    stray_d    = stray_q;

    i_reqack    = 1'b0;
    i_respcyc   = 1'b0;
    i_resp      = '0;
    i_resptag   = '0;
    d_reqack    = 1'b0;
    d_respcyc   = 1'b0;
    d_resp      = '0;
    d_resptag   = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;

    own_d     = (state_q == S_D_REQ) || (state_q == S_D_RESP);
    in_req    = (state_q == S_I_REQ) || (state_q == S_D_REQ);
    in_resp   = (state_q == S_I_RESP) || (state_q == S_D_RESP);
    x_reqcyc  = own_d ? d_reqcyc  : i_reqcyc;
    x_req     = own_d ? d_req     : i_req;
    x_reqtag  = own_d ? d_reqtag  : i_reqtag;
    x_respack = own_d ? d_respack : i_respack;

    req_fire  = in_req && x_reqcyc && bus_reqack;
    resp_fire = in_resp && bus_respcyc && x_respack;
    open_beat = (cnt_q == '0);
    // A configuration where both encodings coincide degrades to read-only.
    beat_is_write = open_beat ? ((x_reqtag == WRITE_TAG) && (WRITE_TAG != READ_TAG))
                              : is_write_q;

    if (in_req) begin
      bus_reqcyc = x_reqcyc;
      bus_req    = x_reqcyc ? x_req    : '0;
      bus_reqtag = x_reqcyc ? x_reqtag : '0;
      i_reqack   = !own_d && bus_reqack;
      d_reqack   = own_d && bus_reqack;
    end

    if (in_resp) begin
      i_respcyc   = !own_d && bus_respcyc;
      i_resp      = (!own_d && bus_respcyc) ? bus_resp    : '0;
      i_resptag   = (!own_d && bus_respcyc) ? bus_resptag : '0;
      d_respcyc   = own_d && bus_respcyc;
      d_resp      = (own_d && bus_respcyc) ? bus_resp    : '0;
      d_resptag   = (own_d && bus_respcyc) ? bus_resptag : '0;
      bus_respack = x_respack;
    end

    // Writes stay in the REQ states, so any response outside RESP is unsolicited.
    if (bus_respcyc && !in_resp) stray_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (d_reqcyc && (!i_reqcyc || !last_q)) begin
          state_d = S_D_REQ;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (i_reqcyc) begin
          state_d = S_I_REQ;
          last_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_I_REQ, S_D_REQ: begin
        if (req_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (open_beat) is_write_d = beat_is_write;
          if (!beat_is_write) state_d = own_d ? S_D_RESP : S_I_RESP;
          else if (cnt_q == CW'(BEATS)) state_d = S_IDLE;
        end
      end
      S_I_RESP, S_D_RESP: begin
        // The opening beat left cnt at 1, so the last response beat sees BEATS.
        if (resp_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stray_resp = stray_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam logic [12:0] RD = 13'd1;
  localparam logic [12:0] WR = 13'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_reqcyc, i_reqack, i_respcyc, i_respack;
  logic [63:0] i_req, i_resp;
  logic [12:0] i_reqtag, i_resptag;
  logic        d_reqcyc, d_reqack, d_respcyc, d_respack;
  logic [63:0] d_req, d_resp;
  logic [12:0] d_reqtag, d_resptag;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, stray_resp;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_W(64), .TAG_W(13), .BEATS(8), .READ_TAG(RD), .WRITE_TAG(WR)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
    .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(d_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .stray_resp(stray_resp)
  );

  typedef struct packed {
    logic i_reqcyc; logic [63:0] i_req; logic [12:0] i_reqtag; logic i_respack;
    logic d_reqcyc; logic [63:0] d_req; logic [12:0] d_reqtag; logic d_respack;
    logic bus_reqack; logic bus_respcyc; logic [63:0] bus_resp; logic [12:0] bus_resptag;
  } in_t;

  typedef struct packed {
    logic i_reqack; logic i_respcyc; logic [63:0] i_resp; logic [12:0] i_resptag;
    logic d_reqack; logic d_respcyc; logic [63:0] d_resp; logic [12:0] d_resptag;
    logic bus_reqcyc; logic [63:0] bus_req; logic [12:0] bus_reqtag;
    logic bus_respack; logic stray_resp;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  task automatic drive(input in_t a);
    i_reqcyc = a.i_reqcyc; i_req = a.i_req; i_reqtag = a.i_reqtag; i_respack = a.i_respack;
    d_reqcyc = a.d_reqcyc; d_req = a.d_req; d_reqtag = a.d_reqtag; d_respack = a.d_respack;
    bus_reqack = a.bus_reqack; bus_respcyc = a.bus_respcyc;
    bus_resp = a.bus_resp; bus_resptag = a.bus_resptag;
  endtask

  function automatic out_t sample();
    out_t o;
    o.i_reqack = i_reqack; o.i_respcyc = i_respcyc; o.i_resp = i_resp; o.i_resptag = i_resptag;
    o.d_reqack = d_reqack; o.d_respcyc = d_respcyc; o.d_resp = d_resp; o.d_resptag = d_resptag;
    o.bus_reqcyc = bus_reqcyc; o.bus_req = bus_req; o.bus_reqtag = bus_reqtag;
    o.bus_respack = bus_respack; o.stray_resp = stray_resp;
    return o;
  endfunction

  task automatic chk_out(input string n, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(input string n, input in_t a, input out_t e);
    vec_t v;
    v.name = n; v.in = a; v.exp = e;
    tbl.push_back(v);
  endtask

  // Idle/arbitration cycle: nothing granted, every output must be 0.
  task automatic add_arb(input string n, input logic ic, input logic [63:0] ia,
                         input logic dc, input logic [63:0] da, input logic [12:0] dt);
    in_t a; out_t e;
    a = '0; e = '0;
    a.i_reqcyc = ic; a.i_req = ia; a.i_reqtag = RD;
    a.d_reqcyc = dc; a.d_req = da; a.d_reqtag = dt;
    push(n, a, e);
  endtask

  // Granted request beat accepted by memory; other side may keep requesting.
  task automatic add_req(input string n, input logic side_d, input logic [63:0] data,
                         input logic [12:0] tag, input logic oc, input logic [63:0] oa);
    in_t a; out_t e;
    a = '0; e = '0;
    a.bus_reqack = 1'b1;
    if (side_d) begin
      a.d_reqcyc = 1'b1; a.d_req = data; a.d_reqtag = tag;
      a.i_reqcyc = oc;   a.i_req = oa;   a.i_reqtag = RD;
      e.d_reqack = 1'b1;
    end else begin
      a.i_reqcyc = 1'b1; a.i_req = data; a.i_reqtag = tag;
      a.d_reqcyc = oc;   a.d_req = oa;   a.d_reqtag = RD;
      e.i_reqack = 1'b1;
    end
    e.bus_reqcyc = 1'b1; e.bus_req = data; e.bus_reqtag = tag;
    push(n, a, e);
  endtask

  // Response beat from memory routed to the owner with the owner's ack.
  task automatic add_resp(input string n, input logic side_d, input logic [63:0] data,
                          input logic ack, input logic oc, input logic [63:0] oa);
    in_t a; out_t e;
    a = '0; e = '0;
    a.bus_respcyc = 1'b1; a.bus_resp = data; a.bus_resptag = RD;
    if (side_d) begin
      a.d_respack = ack; a.i_reqcyc = oc; a.i_req = oa; a.i_reqtag = RD;
      e.d_respcyc = 1'b1; e.d_resp = data; e.d_resptag = RD;
    end else begin
      a.i_respack = ack; a.d_reqcyc = oc; a.d_req = oa; a.d_reqtag = RD;
      e.i_respcyc = 1'b1; e.i_resp = data; e.i_resptag = RD;
    end
    e.bus_respack = ack;
    push(n, a, e);
  endtask

  task automatic do_reset();
    in_t z;
    z = '0;
    @(negedge clk);
    reset = 1'b0;
    drive(z);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    in_t z, a;
    z = '0;

    // Single I read, then a tie (last = I) goes to D while I waits.
    add_arb("i_arb", 1'b1, 64'h1000, 1'b0, 64'h0, RD);
    add_req("i_open", 1'b0, 64'h1000, RD, 1'b0, 64'h0);
    for (int k = 0; k < 8; k++) add_resp("i_beat", 1'b0, 64'(k), 1'b1, 1'b0, 64'h0);
    add_arb("tie1", 1'b1, 64'h1100, 1'b1, 64'h3000, RD);
    add_req("tie1_d_open", 1'b1, 64'h3000, RD, 1'b1, 64'h1100);
    for (int k = 0; k < 8; k++) add_resp("d_beat", 1'b1, 64'hD0 + 64'(k), 1'b1, 1'b1, 64'h1100);
    add_arb("i_wait", 1'b1, 64'h1100, 1'b0, 64'h0, RD);
    add_req("i2_open", 1'b0, 64'h1100, RD, 1'b0, 64'h0);
    for (int k = 0; k < 8; k++) add_resp("i2_beat", 1'b0, 64'h100 + 64'(k), 1'b1, 1'b0, 64'h0);
    // Next tie with last = I: D wins again, this time with a write.
    add_arb("tie2", 1'b1, 64'h1200, 1'b1, 64'h2040, WR);
    add_req("w_open", 1'b1, 64'h2040, WR, 1'b1, 64'h1200);
    for (int k = 0; k < 8; k++) add_req("w_data", 1'b1, 64'hA0 + 64'(k), WR, 1'b1, 64'h1200);
    add_arb("w_done", 1'b1, 64'h1200, 1'b0, 64'h0, RD);
    add_req("i3_open", 1'b0, 64'h1200, RD, 1'b0, 64'h0);
    // Back-pressure: ack 1,0,1,...,1 -> 8 accepted beats over 15 cycles.
    for (int k = 0; k < 15; k++)
      add_resp("bp_beat", 1'b0, 64'h200 + 64'(k / 2), (k % 2) == 0, 1'b0, 64'h0);
    add_arb("bp_done", 1'b0, 64'h0, 1'b1, 64'h3300, RD);
    add_req("d_after_bp", 1'b1, 64'h3300, RD, 1'b0, 64'h0);

    // Reset state, with busy inputs to show outputs stay quiet.
    reset = 1'b0;
    a = '0;
    a.i_reqcyc = 1'b1; a.i_req = 64'h1000; a.i_reqtag = RD; a.i_respack = 1'b1;
    a.bus_reqack = 1'b1; a.bus_respcyc = 1'b1; a.bus_resp = 64'h55;
    drive(a);
    #12;
    chk_out("reset_state", sample(), '0);
    drive(z);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[idx]) begin
      @(negedge clk);
      drive(tbl[idx].in);
      #1;
      chk_out($sformatf("%s[%0d]", tbl[idx].name, idx), sample(), tbl[idx].exp);
    end

    // Stray response in IDLE.
    do_reset();
    @(negedge clk);
    bus_respcyc = 1'b1; bus_resp = 64'h77; bus_resptag = RD; i_respack = 1'b1; d_respack = 1'b1;
    #1;
    chk("stray_respack", 64'(bus_respack), 64'd0);
    chk("stray_routed", 64'({i_respcyc, d_respcyc}), 64'd0);
    @(negedge clk);
    drive(z);
    #1;
    chk("stray_set", 64'(stray_resp), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("stray_sticky", 64'(stray_resp), 64'd1);
    reset = 1'b0;
    #1;
    chk("stray_reset", 64'(stray_resp), 64'd0);

    // Reset during the 4th response beat, then a clean read.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_reqcyc = 1'b1; i_req = 64'h1000; i_reqtag = RD;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("rst_i_open_ack", 64'(i_reqack), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_reqcyc = 1'b0; bus_reqack = 1'b0;
      bus_respcyc = 1'b1; bus_resp = 64'h40 + 64'(k); bus_resptag = RD; i_respack = 1'b1;
      #1;
      chk("rst_pre_beat", 64'({i_respcyc, i_resp[7:0]}), 64'({1'b1, 8'h40 + 8'(k)}));
    end
    reset = 1'b0;
    #1;
    chk_out("rst_mid_outputs", sample(), '0);
    drive(z);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_reqcyc = 1'b1; i_req = 64'h1000; i_reqtag = RD;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("post_rst_open", 64'({i_reqack, bus_reqcyc}), 64'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_reqcyc = 1'b0; bus_reqack = 1'b0;
      bus_respcyc = 1'b1; bus_resp = 64'h50 + 64'(k); bus_resptag = RD; i_respack = 1'b1;
      #1;
      chk("post_rst_beat", 64'({i_respcyc, i_resp[7:0]}), 64'({1'b1, 8'h50 + 8'(k)}));
    end
    @(negedge clk);
    #1;
    chk("post_rst_idle", 64'({i_respcyc, bus_respack}), 64'd0);
    drive(z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
